// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the display scan controller.
//   scan_state_e : controller state encoding (CLEAR, BLANK, SCAN)
//   MSG_LEN      : number of message slots
//   DIGITS       : number of 7-segment digits on the display
//   BLANK_CYCLES : all-off cycles inserted before each lit slot when the
//                  anti-ghosting gap is built in
//   CHAR_BLANK   : character code driven when nothing is lit / after clear
package display_pkg;
    localparam int         MSG_LEN      = 16;
    localparam int         DIGITS       = 4;
    localparam int         BLANK_CYCLES = 2;
    localparam logic [3:0] CHAR_BLANK   = 4'h0;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        BLANK = 2'd1,
        SCAN  = 2'd2
    } scan_state_e;
endpackage

// File: rtl/scan_timer.sv
// scan_timer -- slot / blank / frame timing for the display scan controller.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   scan_active    : controller is in SCAN (count DIGIT_CYCLES per slot)
//   blank_active   : controller is in BLANK (count BLANK_CYCLES)
//   last_digit     : digit 0 is the one currently lit
//   scroll_en      : allow the frame counter to advance
//   slot_done      : pulse in the last cycle of a lit slot
//   blank_done     : pulse in the last cycle of a blank gap
//   frame_done     : pulse when the SCROLL_FRAMES-th counted frame ends
//                    (i.e. the scroll offset must step at this edge)
module scan_timer #(
    parameter int DIGIT_CYCLES  = 16,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic scan_active,
    input  logic blank_active,
    input  logic last_digit,
    input  logic scroll_en,
    output logic slot_done,
    output logic blank_done,
    output logic frame_done
);
    import display_pkg::*;

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          frame_end;

    always_comb begin
        slot_done  = scan_active  && (cnt_q == CW'(DIGIT_CYCLES - 1));
        blank_done = blank_active && (cnt_q == CW'(BLANK_CYCLES - 1));
        frame_end  = slot_done && last_digit;
        frame_done = frame_end && scroll_en && (frame_q == FW'(SCROLL_FRAMES - 1));

        // One counter serves both lit slots and blank gaps; it restarts at
        // every slot/gap boundary and idles at zero otherwise.
        cnt_d = '0;
        if ((scan_active || blank_active) && !slot_done && !blank_done)
            cnt_d = cnt_q + CW'(1);

        // Frames are only counted while scrolling is enabled, so the count
        // freezes together with the offset when scroll_en is low.
        frame_d = frame_q;
        if (frame_end && scroll_en)
            frame_d = frame_done ? '0 : frame_q + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            frame_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller -- scrolling 4-digit multiplexed LED message display.
// Holds a 16 x 4-bit message and a scroll offset; scans digits 3,2,1,0 lighting
// msg[(offset + 3 - k) mod 16] on digit k, stepping the offset every
// SCROLL_FRAMES frames while scroll_en is high.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_char, wr_ready : message write port (ready low in CLEAR)
//   scroll_en           : enables offset advance
//   an3..an0            : active-low digit anodes (an3 leftmost), registered
//   char                : code of the lit digit, registered with the anodes
// Build option: define DISPLAY_SCAN_BLANK_GAP_EN to insert BLANK_CYCLES
// all-off cycles before every lit slot (anti-ghosting).
module display_scan_controller #(
    parameter int DIGIT_CYCLES  = 16,
    parameter int SCROLL_FRAMES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_char,
    output logic       wr_ready,
    input  logic       scroll_en,
    output logic       an3,
    output logic       an2,
    output logic       an1,
    output logic       an0,
    output logic [3:0] char
);
    import display_pkg::*;

`ifdef DISPLAY_SCAN_BLANK_GAP_EN
    localparam scan_state_e SLOT_ENTRY = BLANK;
`else
    localparam scan_state_e SLOT_ENTRY = SCAN;
`endif

    scan_state_e state_q, state_d;
    logic [3:0]  clr_idx_q, clr_idx_d;
    logic [3:0]  offset_q, offset_d;
    logic [1:0]  digit_q, digit_d;
    logic [3:0]  msg_q [MSG_LEN];
    logic [3:0]  msg_d [MSG_LEN];
    logic [3:0]  an_q, an_d;
    logic [3:0]  char_q, char_d;
    logic [3:0]  idx_d;
    logic        wr_acc;
    logic        slot_done, blank_done, frame_done;

    scan_timer #(
        .DIGIT_CYCLES  (DIGIT_CYCLES),
        .SCROLL_FRAMES (SCROLL_FRAMES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .scan_active  (state_q == SCAN),
        .blank_active (state_q == BLANK),
        .last_digit   (digit_q == 2'd0),
        .scroll_en    (scroll_en),
        .slot_done    (slot_done),
        .blank_done   (blank_done),
        .frame_done   (frame_done)
    );

    assign wr_ready = (state_q != CLEAR);
    assign wr_acc   = wr_en && wr_ready;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        digit_d   = digit_q;
        offset_d  = offset_q;
        msg_d     = msg_q;

        case (state_q)
            CLEAR: begin
                msg_d[clr_idx_q] = CHAR_BLANK;
                clr_idx_d        = clr_idx_q + 4'd1;
                if (clr_idx_q == 4'(MSG_LEN - 1)) begin
                    state_d = SLOT_ENTRY;
                    digit_d = 2'(DIGITS - 1);
                end
            end
            BLANK: begin
                if (blank_done)
                    state_d = SCAN;
            end
            SCAN: begin
                if (slot_done) begin
                    digit_d = digit_q - 2'd1;   // 0 wraps back to 3
                    state_d = SLOT_ENTRY;
                end
            end
            default: state_d = CLEAR;
        endcase

        if (wr_acc)
            msg_d[wr_addr] = wr_char;
        if (frame_done)
            offset_d = offset_q + 4'd1;

        // Outputs are computed from next-state values so anodes and char
        // land on the same edge. Reading msg_d forwards a write accepted
        // this cycle, so the new char appears on the very next cycle.
        idx_d = offset_d + 4'd3 - {2'b00, digit_d};
        if (state_d == SCAN) begin
            an_d   = ~(4'b0001 << digit_d);
            char_d = msg_d[idx_d];
        end else begin
            an_d   = 4'hF;
            char_d = CHAR_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            offset_q  <= '0;
            digit_q   <= 2'(DIGITS - 1);
            an_q      <= 4'hF;
            char_q    <= CHAR_BLANK;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            offset_q  <= offset_d;
            digit_q   <= digit_d;
            an_q      <= an_d;
            char_q    <= char_d;
        end
    end

    // Message storage is not reset; CLEAR zeroes it right after reset.
    always_ff @(posedge clk) begin
        msg_q <= msg_d;
    end

    assign {an3, an2, an1, an0} = an_q;
    assign char = char_q;
endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;
    localparam int DC = 4;
`ifdef DISPLAY_SCAN_BLANK_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = 4'h0;
    logic [3:0] wr_char = 4'h0;
    logic       wr_ready;
    logic       scroll_en = 1'b0;
    logic       an3, an2, an1, an0;
    logic [3:0] char;
    logic [3:0] an;

    int compared = 0;
    int mismatched = 0;

    assign an = {an3, an2, an1, an0};

    display_scan_controller #(.DIGIT_CYCLES(DC), .SCROLL_FRAMES(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_ready(wr_ready), .scroll_en(scroll_en),
        .an3(an3), .an2(an2), .an1(an1), .an0(an0), .char(char)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_an(input logic [3:0] pat, input string tag);
        int n = 0;
        while (an !== pat && n < 200) begin
            step();
            n++;
        end
        chk(tag, an, pat);
    endtask

    // Move to the first cycle of a fresh digit-3 slot.
    task automatic align3(input string tag);
        int n = 0;
        while (an === 4'b0111 && n < 200) begin
            step();
            n++;
        end
        wait_an(4'b0111, tag);
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_rst_an"}, an, 4'hF);
        chk({tag, "_rst_ready"}, {3'b000, wr_ready}, 4'h0);
        chk({tag, "_rst_char"}, char, 4'h0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk({tag, "_clr_ready"}, {3'b000, wr_ready}, 4'h0);
            chk({tag, "_clr_an"}, an, 4'hF);
        end
        step();
        chk({tag, "_ready_after_clear"}, {3'b000, wr_ready}, 4'h1);
    endtask

    initial begin
        logic [3:0] e;

        // Reset and CLEAR sweep, then all chars zero for a frame.
        step();
        step();
        check_clear("init");
        for (int i = 0; i < 4 * (DC + GAP); i++) begin
            chk("cleared_char", char, 4'h0);
            step();
        end

        // Slots 0..3 = 1,2,3,4; digits scan 3..0 for DC cycles each.
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_char = 4'(i + 1);
            step();
        end
        wr_en = 1'b0;
        align3("align_scan");
        for (int fr = 0; fr < 2; fr++) begin
            for (int d = 3; d >= 0; d--) begin
                for (int c = 0; c < DC; c++) begin
                    chk("scan_an", an, ~(4'b0001 << d));
                    chk("scan_char", char, 4'(4 - d));
                    step();
                end
                for (int g = 0; g < GAP; g++) begin
                    chk("gap_an", an, 4'hF);
                    step();
                end
            end
        end
        chk("frame_len_an", an, 4'b0111);

        // Write 9 to the displayed slot mid-slot.
        step();
        wr_en = 1'b1; wr_addr = 4'h0; wr_char = 4'h9;
        chk("hazard_old", char, 4'h1);
        step();
        chk("hazard_same_slot", an, 4'b0111);
        chk("hazard_new", char, 4'h9);
        // Back-to-back writes to slot 1: last one wins.
        wr_addr = 4'h1; wr_char = 4'h5;
        step();
        wr_char = 4'h7;
        step();
        wr_en = 1'b0;
        wait_an(4'b1011, "lastwin_align");
        chk("lastwin_char", char, 4'h7);

        // Message F..0, scroll one offset per frame through a full wrap.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_char = 4'(15 - i);
            step();
        end
        wr_en = 1'b0;
        chk("load_ready", {3'b000, wr_ready}, 4'h1);
        align3("align_scroll");
        scroll_en = 1'b1;
        for (int f = 0; f < 17; f++) begin
            for (int d = 3; d >= 0; d--) begin
                wait_an(~(4'b0001 << d), "scroll_an");
                e = 4'(15 - ((f % 16) + 3 - d) % 16);
                chk((f == 14) ? "scroll_wrap14" : "scroll_char", char, e);
            end
        end

        // Run to offset 5 (digit 3 shows msg[5]=A), then pulse reset mid-slot.
        begin
            int n = 0;
            while (!(an === 4'b0111 && char === 4'hA) && n < 300) begin
                step();
                n++;
            end
            chk("reach_off5", char, 4'hA);
        end
        scroll_en = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_clear("midscan");
        // Offset restarted at 0: digit 3 shows slot 0, not slot 5.
        wr_en = 1'b1; wr_addr = 4'h0; wr_char = 4'h3;
        step();
        wr_addr = 4'h5; wr_char = 4'h6;
        step();
        wr_en = 1'b0;
        align3("align_off0");
        chk("offset_zero", char, 4'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
